// File: rtl/gate_check_pkg.sv
// Shared types and truth-table constants for the 2-input gate checker.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int NUM_VECTORS = 4;

  // Bit index is {a,b}
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_truth_checker.sv
// Exhaustive 2-input gate checker: each vector held SETTLE_CYCLES+1 cycles, done 4*(SETTLE_CYCLES+1) cycles after start.
// start is accepted only in IDLE; while a run is active it is ignored, never queued.
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [3:0] TRUTH         = TT_NAND
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       f,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LAST_IDX    = 2'(NUM_VECTORS - 1);

  state_t     state_q, state_d;
  logic [1:0] idx;
  logic [7:0] cnt;
  logic       mismatch;
  logic [2:0] err_next;
  logic [3:0] fail_next;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE:  if (cnt == SETTLE_LAST) state_d = SAMPLE;
      SAMPLE:  state_d = (idx == LAST_IDX) ? DONE : SETTLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Case-inequality so an X/Z gate output is reported as a failure in simulation
  always_comb begin
    mismatch  = (f !== TRUTH[idx]);
    err_next  = err_count + 3'(mismatch);
    fail_next = fail_vec | ({3'b000, mismatch} << idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= 2'd0;
      cnt       <= 8'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            idx       <= 2'd0;
            cnt       <= 8'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
          end
        end
        SETTLE: begin
          if (cnt != SETTLE_LAST) cnt <= cnt + 8'd1;
        end
        SAMPLE: begin
          err_count <= err_next;
          fail_vec  <= fail_next;
          if (idx == LAST_IDX) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_next == 3'd0);
          end else begin
            idx    <= idx + 2'd1;
            {a, b} <= idx + 2'd1;
            cnt    <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: behavioural gate driven from a/b, scoreboard of expected run results.
module tb_gate_truth_checker;
  import gate_check_pkg::*;

  typedef struct packed {
    logic [2:0] err;
    logic [3:0] fv;
    logic       pass;
  } res_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       f;
  logic       a, b, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic [3:0] gate_tt;

  res_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  assign f = gate_tt[{a, b}];

  gate_truth_checker #(
    .SETTLE_CYCLES(4),
    .TRUTH(TT_NAND)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .f(f),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .fail_vec(fail_vec)
  );

  task automatic run_check(input logic hold, output int waited);
    res_t e;
    res_t got_r;
    bit   got;
    e.fv   = gate_tt ^ TT_NAND;
    e.err  = 3'($countones(e.fv));
    e.pass = (e.fv == 4'd0);
    sb.push_back(e);
    start  = 1'b1;
    waited = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      waited++;
    end while (!busy && waited < 10);
    n_tests++;
    if (busy !== 1'b1) begin
      $display("FAIL accept: busy=%b required 1", busy);
      n_fail++;
    end
    n_tests++;
    if ({err_count, fail_vec, pass} !== 8'd0) begin
      $display("FAIL clear_on_start: err=%0d fv=%b pass=%b required 0 0000 0", err_count, fail_vec, pass);
      n_fail++;
    end
    if (!hold) start = 1'b0;
    got = 0;
    for (int j = 0; j <= 40 && !got; j++) begin
      if (j > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (done === 1'b1) begin
        got = 1;
        n_tests++;
        if (j != 20) begin
          $display("FAIL done_time: done at cycle %0d required 20", j);
          n_fail++;
        end
        n_tests++;
        if (busy !== 1'b0) begin
          $display("FAIL busy_fall: busy=%b required 0", busy);
          n_fail++;
        end
        n_tests++;
        if (sb.size() == 0) begin
          $display("FAIL scoreboard: empty queue at done");
          n_fail++;
        end else begin
          got_r = sb.pop_front();
          if ({err_count, fail_vec, pass} !== got_r) begin
            $display("FAIL result: err=%0d fv=%b pass=%b required err=%0d fv=%b pass=%b",
                     err_count, fail_vec, pass, got_r.err, got_r.fv, got_r.pass);
            n_fail++;
          end
        end
      end else if (j < 20) begin
        n_tests++;
        if ({a, b} !== 2'(j / 5) || busy !== 1'b1) begin
          $display("FAIL vector: cycle %0d ab=%b%b busy=%b required ab=%b busy=1",
                   j, a, b, busy, 2'(j / 5));
          n_fail++;
        end
      end
    end
    n_tests++;
    if (!got) begin
      $display("FAIL done_timeout: no done within 40 cycles");
      n_fail++;
    end
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || pass !== e.pass) begin
      $display("FAIL done_pulse: done=%b pass=%b required done=0 pass=%b", done, pass, e.pass);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    start   = 1'b0;
    gate_tt = TT_NAND;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({a, b, busy, done, pass, err_count, fail_vec} !== 12'd0) begin
      $display("FAIL reset: a=%b b=%b busy=%b done=%b pass=%b err=%0d fv=%b required all 0",
               a, b, busy, done, pass, err_count, fail_vec);
      n_fail++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_nand();
    int w;
    gate_tt = TT_NAND;
    run_check(1'b0, w);
  endtask

  task automatic test_and_gate();
    int w;
    gate_tt = TT_AND;
    run_check(1'b0, w);
  endtask

  task automatic test_stuck_one();
    int w;
    gate_tt = 4'b1111;
    run_check(1'b0, w);
  endtask

  task automatic test_back_to_back();
    int w;
    gate_tt = TT_XOR;
    run_check(1'b1, w);
    run_check(1'b1, w);
    n_tests++;
    if (w != 1) begin
      $display("FAIL rearm: second start accepted after %0d edges required 1", w);
      n_fail++;
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int w;
    int dones;
    gate_tt = TT_NAND;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({a, b} !== 2'b01 || busy !== 1'b1) begin
      $display("FAIL midrun: ab=%b%b busy=%b required ab=01 busy=1", a, b, busy);
      n_fail++;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({a, b, busy, done, pass, err_count, fail_vec} !== 12'd0) begin
      $display("FAIL mid_reset: a=%b b=%b busy=%b done=%b pass=%b err=%0d fv=%b required all 0",
               a, b, busy, done, pass, err_count, fail_vec);
      n_fail++;
    end
    dones = 0;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    n_tests++;
    if (dones != 0) begin
      $display("FAIL aborted_run: %0d done/busy cycles after reset required 0", dones);
      n_fail++;
    end
    gate_tt = TT_NAND;
    run_check(1'b0, w);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    test_reset();
    test_good_nand();
    test_and_gate();
    test_stuck_one();
    test_back_to_back();
    test_mid_reset();
    n_tests++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
      n_fail++;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

In-circuit exhaustive checker for a 2-input combinational gate such as the CMOS NAND cell. It is the response end of the gate stimulus flow:
- Applies the four input vectors {a,b} = 00, 01, 10, 11 in order.
- Waits a programmable settle time after each vector, then samples the gate output.
- Compares the sample against a parameterised truth table and reports error count, failing vectors and pass/fail.

It sits between a control/status source (start/done) and the gate under test.

## Interface
Parameters:
- SETTLE_CYCLES, 4, cycles each vector is held before sampling; legal range 1..255.
- TRUTH, 4'b0111 (NAND), expected output; bit index = {a,b}.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a check run; sampled only in IDLE.
- f  in  1  output of gate under test; same clock domain, not resynchronised.
- a  out  1  gate input A, registered.
- b  out  1  gate input B, registered.
- busy  out  1  high from run start through last SAMPLE.
- done  out  1  one-cycle pulse when run completes.
- pass  out  1  1 when the last completed run had zero errors; held until next start.
- err_count  out  3  mismatches in the current/last run (0..4).
- fail_vec  out  4  bit {a,b} set if that vector failed.

## Operation
- Reset values: a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, state=IDLE, idx=0, settle counter=0.
- States and transitions:
  - IDLE: start=1 -> SETTLE. On that edge: idx=0, a=b=0, err_count=0, fail_vec=0, pass=0, busy=1.
  - SETTLE: count 0..SETTLE_CYCLES-1; last count -> SAMPLE.
  - SAMPLE, one cycle: if f != TRUTH[idx], increment err_count and set fail_vec[idx]. In simulation X/Z on f counts as a mismatch (case-inequality compare). If idx==3 -> DONE with busy=0. Otherwise idx+1, {a,b}=idx+1, settle counter=0 -> SETTLE.
  - DONE, one cycle: done=1, pass=(err_count==0) -> IDLE.
- {a,b} always equals idx while busy; a is the MSB.
- start is ignored in SETTLE, SAMPLE and DONE; no queuing. start held high re-arms only on return to IDLE.
- rst has priority over every transition. Mid-run it returns all outputs to reset values and no done pulse is produced.
- err_count cannot exceed 4, so no saturation logic is needed.

## Timing
- Start accepted at edge k. Vector n is driven from edge k+n·(SETTLE_CYCLES+1).
- f is sampled at edge k+(n+1)·(SETTLE_CYCLES+1)−1, i.e. each vector is held SETTLE_CYCLES+1 cycles.
- done is high in the cycle following edge k+4·(SETTLE_CYCLES+1); with default SETTLE_CYCLES=4 that is edge k+20.
- busy falls on the same edge done rises.
- The earliest next start is accepted on the edge after done falls.
- Gate propagation plus routing must be less than SETTLE_CYCLES clock periods.

## Structure
- Shared package gate_check_pkg holds:
  - state typedef (IDLE, SETTLE, SAMPLE, DONE);
  - NUM_VECTORS=4;
  - truth-table constants TT_NAND=4'b0111, TT_NOR=4'b0001, TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110.
- Single module, no sub-module. The FSM, settle counter and result registers are inline.

## Test plan
- Reset: rst high for 2 cycles -> a=b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
- Good NAND, SETTLE_CYCLES=4, start pulse at edge k:
  - {a,b} steps 00, 01, 10, 11, each held 5 cycles;
  - done pulses after edge k+20; pass=1, err_count=0, fail_vec=4'b0000.
- AND gate substituted with TRUTH=TT_NAND -> err_count=4, fail_vec=4'b1111, pass=0.
- f stuck at 1 -> only vector 11 fails: err_count=1, fail_vec=4'b1000, pass=0.
- start held high for the whole run, then a second start:
  - no restart while busy;
  - the second run clears err_count/fail_vec/pass at acceptance and reproduces identical results.
- rst asserted at edge k+7 mid-run:
  - all outputs return to reset values on that edge and no done is produced;
  - a following start completes a full 20-cycle run normally.
